// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: next-PC select encodings,
// opcode constants used by the fetch unit and control unit, and the fetch
// FSM state encoding.
package cpu_pkg;

    // PCSrc encodings driven by the control unit
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    // Opcode field ir[31:26]
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_REQ  = 3'd1,
        FS_WAIT = 3'd2,
        FS_DONE = 3'd3,
        FS_ERR  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC computation for the fetch unit.
// Ports:
//   pc          current PC
//   pc_src      next-PC select (PC_SEQ / PC_BR / PC_JR / PC_J)
//   imm_ext     sign-extended branch offset in words
//   jr_target   register value for jr
//   ir_index    ir[25:0], jump target index
//   pc_plus4    pc + 4
//   next_pc     selected next PC
//   jr_misalign high when pc_src selects jr and jr_target is not word aligned
module next_pc_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jr_target,
    input  logic [25:0] ir_index,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        jr_misalign
);

    logic [31:0] br_target;
    logic [31:0] jr_aligned;
    logic [31:0] j_target;

    assign pc_plus4   = pc + 32'd4;
    // Offset is in words; 32-bit wrap is intended, no overflow detection.
    assign br_target  = pc_plus4 + (imm_ext << 2);
    assign jr_aligned = {jr_target[31:2], 2'b00};
    assign j_target   = {pc_plus4[31:28], ir_index, 2'b00};

    always_comb begin
        next_pc     = pc_plus4;
        jr_misalign = 1'b0;
        case (pc_src)
            PC_SEQ: next_pc = pc_plus4;
            PC_BR:  next_pc = br_target;
            PC_JR: begin
                next_pc     = jr_aligned;
                jr_misalign = (jr_target[1:0] != 2'b00);
            end
            PC_J:   next_pc = j_target;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch unit: owns PC and IR, runs the req/ack handshake to
// instruction memory, and applies PC updates commanded by the control unit.
//
//   state | meaning
//   IDLE  | waiting for fetch_start; PC updates allowed
//   REQ   | first request cycle, imem_req=1
//   WAIT  | request held, counting cycles without ack
//   DONE  | fetch_done pulse, back to IDLE next cycle
//   ERR   | memory timeout; stuck here until reset
//
// Ports:
//   CLK, reset       clock, async active-high reset
//   PCWre, PCSrc     PC write enable and next-PC select
//   IRWre            IR load enable on fetch completion
//   fetch_start      request a fetch at the current PC
//   imm_ext          branch offset (words)
//   jr_target        register value for jr
//   imem_req/addr    memory request and address
//   imem_ack/rdata   memory acknowledge and instruction word
//   pc, pc_plus4     current PC and PC+4
//   ir, op           instruction register and its opcode field
//   fetch_busy       FSM not in IDLE
//   fetch_done       one-cycle completion pulse
//   fetch_err        sticky error flag
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
)
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic        IRWre,
    input  logic        fetch_start,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic        fetch_busy,
    output logic        fetch_done,
    output logic        fetch_err
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    fetch_state_t state, state_nxt;
    logic [7:0]   wait_cnt;
    logic [31:0]  next_pc;
    logic         jr_misalign;
    logic         in_handshake;
    logic         load_ir;
    logic         pc_update;
    logic         pc_violation;

    next_pc_mux u_next_pc_mux (
        .pc          (pc),
        .pc_src      (PCSrc),
        .imm_ext     (imm_ext),
        .jr_target   (jr_target),
        .ir_index    (ir[25:0]),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc),
        .jr_misalign (jr_misalign)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= FS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE: if (fetch_start) state_nxt = FS_REQ;
            FS_REQ:  state_nxt = imem_ack ? FS_DONE : FS_WAIT;
            FS_WAIT: begin
                if (imem_ack)                    state_nxt = FS_DONE;
                else if (wait_cnt == MAX_WAIT_C) state_nxt = FS_ERR;
            end
            FS_DONE: state_nxt = FS_IDLE;
            FS_ERR:  state_nxt = FS_ERR;
            default: state_nxt = FS_IDLE;
        endcase
    end

    // Outputs decoded straight from state so imem_req drops the moment
    // reset asserts.
    assign in_handshake = (state == FS_REQ) || (state == FS_WAIT);
    assign imem_req     = in_handshake;
    assign fetch_busy   = (state != FS_IDLE);
    assign fetch_done   = (state == FS_DONE);
    assign op           = ir[31:26];

    assign load_ir      = in_handshake && imem_ack && IRWre;
    assign pc_update    = PCWre && (state == FS_IDLE);
    assign pc_violation = PCWre && (state != FS_IDLE);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else if (state == FS_REQ && !imem_ack) begin
            wait_cnt <= 8'd1;
        end else if (state == FS_WAIT && !imem_ack && wait_cnt != MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Address is captured from the PC before any same-cycle update lands,
    // so a simultaneous fetch_start/PCWre fetches from the old PC.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            imem_addr <= 32'd0;
        end else if (state == FS_IDLE && fetch_start) begin
            imem_addr <= pc;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ir <= 32'd0;
        end else if (load_ir) begin
            ir <= imem_rdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_update) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if ((state_nxt == FS_ERR) || pc_violation || (pc_update && jr_misalign)) begin
            fetch_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic        IRWre;
    logic        fetch_start;
    logic [31:0] imm_ext;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic [5:0]  op;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;

    int n_vec = 0;
    int n_bad = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .IRWre       (IRWre),
        .fetch_start (fetch_start),
        .imm_ext     (imm_ext),
        .jr_target   (jr_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .ir          (ir),
        .op          (op),
        .fetch_busy  (fetch_busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
    endtask

    task automatic idle_inputs();
        PCWre = 1'b0; PCSrc = PC_SEQ; IRWre = 1'b1; fetch_start = 1'b0;
        imm_ext = 32'd0; jr_target = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        chk("rst_pc",   pc, 32'h0);
        chk("rst_ir",   ir, 32'h0);
        chk("rst_req",  {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_err",  {31'd0, fetch_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Fetch with ack in the REQ cycle.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("f1_req",  {31'd0, imem_req}, 32'd1);
        chk("f1_addr", imem_addr, 32'h0);
        chk("f1_done_early", {31'd0, fetch_done}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hE000_0010;
        tick();
        imem_ack = 1'b0;
        chk("f1_done", {31'd0, fetch_done}, 32'd1);
        chk("f1_ir",   ir, 32'hE000_0010);
        chk("f1_op",   {26'd0, op}, {26'd0, OP_J});
        chk("f1_reqlow", {31'd0, imem_req}, 32'd0);
        tick();
        chk("f1_done_end", {31'd0, fetch_done}, 32'd0);
        chk("f1_idle", {31'd0, fetch_busy}, 32'd0);

        // Sequential steps to 0x10, then branch back and jump.
        PCWre = 1'b1; PCSrc = PC_SEQ;
        for (int i = 0; i < 4; i++) tick();
        chk("seq_pc", pc, 32'h10);
        PCSrc = PC_BR; imm_ext = 32'hFFFF_FFFE;
        tick();
        chk("br_pc", pc, 32'h0C);
        PCSrc = PC_J;
        tick();
        chk("j_pc", pc, 32'h40);
        PCWre = 1'b0;

        // Ack delayed 3 cycles, IRWre=0 so ir must stay put.
        IRWre = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dly_req%0d", i), {31'd0, imem_req}, 32'd1);
            chk($sformatf("dly_addr%0d", i), imem_addr, 32'h40);
            chk($sformatf("dly_nodone%0d", i), {31'd0, fetch_done}, 32'd0);
            if (i == 3) begin
                imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
            end
            tick();
        end
        imem_ack = 1'b0;
        chk("dly_done", {31'd0, fetch_done}, 32'd1);
        chk("dly_ir_kept", ir, 32'hE000_0010);
        tick();
        chk("dly_done_once", {31'd0, fetch_done}, 32'd0);
        IRWre = 1'b1;

        // Misaligned jr.
        PCWre = 1'b1; PCSrc = PC_JR; jr_target = 32'h0000_0102;
        tick();
        PCWre = 1'b0;
        chk("jr_pc",  pc, 32'h100);
        chk("jr_err", {31'd0, fetch_err}, 32'd1);
        chk("jr_idle", {31'd0, fetch_busy}, 32'd0);
        do_reset();
        chk("jr_err_clr", {31'd0, fetch_err}, 32'd0);

        // PCWre during WAIT is a protocol violation.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        PCWre = 1'b1; PCSrc = PC_SEQ;
        tick();
        PCWre = 1'b0;
        chk("viol_pc",  pc, 32'h0);
        chk("viol_err", {31'd0, fetch_err}, 32'd1);
        do_reset();

        // Same-cycle fetch_start + PCWre at pc=0x20.
        PCWre = 1'b1; PCSrc = PC_SEQ;
        for (int i = 0; i < 8; i++) tick();
        PCWre = 1'b0;
        chk("pre_pc20", pc, 32'h20);
        fetch_start = 1'b1; PCWre = 1'b1;
        tick();
        fetch_start = 1'b0; PCWre = 1'b0;
        chk("same_addr", imem_addr, 32'h20);
        chk("same_pc",   pc, 32'h24);
        chk("same_req",  {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
        tick();
        imem_ack = 1'b0;
        chk("same_done", {31'd0, fetch_done}, 32'd1);
        tick();

        // PC wrap.
        PCWre = 1'b1; PCSrc = PC_JR; jr_target = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        PCSrc = PC_SEQ;
        chk("wrap_p4", pc_plus4, 32'h0);
        tick();
        PCWre = 1'b0;
        chk("wrap_pc",  pc, 32'h0);
        chk("wrap_err", {31'd0, fetch_err}, 32'd0);

        // Timeout: REQ plus MAX_WAIT WAIT cycles without ack, then ERR.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_req_last", {31'd0, imem_req}, 32'd1);
        chk("to_err_early", {31'd0, fetch_err}, 32'd0);
        tick();
        chk("to_err",  {31'd0, fetch_err}, 32'd1);
        chk("to_req",  {31'd0, imem_req}, 32'd0);
        chk("to_busy", {31'd0, fetch_busy}, 32'd1);
        PCWre = 1'b1; PCSrc = PC_SEQ;
        tick(); tick();
        PCWre = 1'b0;
        chk("to_pc_frozen", pc, 32'h0);
        chk("to_stuck", {31'd0, fetch_busy}, 32'd1);
        do_reset();

        // Reset during the 2nd WAIT cycle, then a stray ack.
        PCWre = 1'b1; PCSrc = PC_SEQ;
        tick();
        PCWre = 1'b0;
        chk("mr_pc4", pc, 32'h4);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick(); tick();
        chk("mr_in_wait", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_req_drop", {31'd0, imem_req}, 32'd0);
        chk("mr_pc", pc, 32'h0);
        #1;
        reset = 1'b0;
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("mr_nodone", {31'd0, fetch_done}, 32'd0);
        chk("mr_ir", ir, 32'h0);
        chk("mr_idle", {31'd0, fetch_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch side of the multi-cycle CPU. It owns the PC and the instruction register (IR), and it runs a req/ack handshake to instruction memory. It carries out the PC-update commands from the control unit (PCWre, PCSrc, IRWre) and returns the fetched opcode to it, along with busy and done status. It sits between the control unit, the register file/sign-extender outputs and the instruction memory port.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MAX_WAIT, 15, maximum cycles in WAIT without imem_ack before a timeout error (range 1..255).

Ports:
CLK  input  1  clock; all state changes on posedge.
reset  input  1  asynchronous, active-high reset.
PCWre  input  1  PC write enable from control unit.
PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jr, 11 jump.
IRWre  input  1  IR load enable on fetch completion.
fetch_start  input  1  one-cycle request to fetch at the current PC.
imm_ext  input  32  sign-extended branch offset, in words.
jr_target  input  32  register value for jr.
imem_req  output  1  memory request, held until ack.
imem_addr  output  32  fetch address, stable while imem_req=1.
imem_ack  input  1  memory acknowledge; imem_rdata is valid in the same cycle.
imem_rdata  input  32  instruction word.
pc  output  32  current PC.
pc_plus4  output  32  pc+4, combinational.
ir  output  32  instruction register.
op  output  6  ir[31:26].
fetch_busy  output  1  FSM is not in IDLE.
fetch_done  output  1  one-cycle pulse when the IR load completes.
fetch_err  output  1  sticky error flag.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, ir=0, FSM=IDLE.
  - imem_req=0, imem_addr=0, fetch_done=0, fetch_err=0.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - fetch_start=1 -> REQ; imem_addr<=pc.
  - fetch_start=0 -> stay.
- REQ:
  - imem_req=1.
  - imem_ack=1 -> DONE; if IRWre=1, ir<=imem_rdata.
  - imem_ack=0 -> WAIT; wait counter<=1.
- WAIT:
  - imem_req=1 and imem_addr stay held.
  - imem_ack=1 -> DONE; if IRWre=1, ir<=imem_rdata.
  - Counter increments each cycle without ack. Counter==MAX_WAIT with no ack -> ERR.
- DONE: fetch_done=1 for exactly this cycle, imem_req=0, then -> IDLE.
- Latency: minimum 2 cycles from fetch_start to fetch_done (ack in the REQ cycle).
- ERR:
  - imem_req=0, fetch_err=1; FSM stays in ERR until reset.
  - fetch_busy=1 while in ERR.
  - PCWre is ignored in ERR.
- IRWre=0 at completion: the handshake still finishes and fetch_done still pulses, but ir is unchanged.
- PC update, on posedge when PCWre=1 and FSM is IDLE:
  - 00: pc <= pc+4.
  - 01: pc <= pc+4+(imm_ext<<2), 32-bit wrap, no overflow detection.
  - 10: pc <= {jr_target[31:2],2'b00}. If jr_target[1:0]!=0, fetch_err is set as well (FSM does not change).
  - 11: pc <= {pc_plus4[31:28], ir[25:0], 2'b00}.
- PCWre=1 while fetch_busy=1: protocol violation. PC is unchanged and fetch_err is set.
- fetch_start while busy is ignored.
- fetch_start and PCWre in the same IDLE cycle: the PC update wins. The fetch is issued from the old pc (imem_addr<=old pc), and the new pc is visible next cycle.
- PC wrap: 32'hFFFF_FFFC + 4 = 0; no error.
- Reset mid-fetch: imem_req drops asynchronously; a late imem_ack after reset is ignored (FSM is in IDLE).

Decomposition:
- Shared package cpu_pkg:
  - PCSrc encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11.
  - Opcode constants shared with the control unit.
  - Fetch FSM state encoding.
- Sub-module next_pc_mux (combinational next-PC computation, including the alignment check).
- Register, FSM and wait counter stay in the top block.

Test Plan:
- Reset, then fetch_start at pc=0 with ack in the REQ cycle and imem_rdata=32'hE000_0010, IRWre=1 -> imem_addr=0; fetch_done pulses 2 cycles after start; ir=32'hE000_0010; op=6'b111000.
- PCWre=1 with PCSrc=01, pc=32'h0000_0010, imm_ext=32'hFFFF_FFFE -> pc=32'h0000_000C. Then PCSrc=11 with ir[25:0]=26'h10 -> pc=32'h0000_0040.
- Ack delayed 3 cycles -> imem_req held 4 cycles with addr stable; one fetch_done pulse. Ack withheld 15 cycles (MAX_WAIT) -> ERR, fetch_err=1, imem_req=0, later PCWre ignored.
- PCSrc=10 with jr_target=32'h0000_0102 -> pc=32'h0000_0100, fetch_err=1. Separately, PCWre during WAIT -> pc unchanged, fetch_err=1.
- fetch_start and PCWre (PCSrc=00) in the same cycle at pc=32'h20 -> imem_addr=32'h20, pc=32'h24 next cycle. Separately, pc=32'hFFFF_FFFC with seq update -> pc=0.
- Assert reset in the 2nd WAIT cycle -> imem_req=0 immediately, pc=RESET_PC; an ack pulse 1 cycle later causes no fetch_done and no ir change.
